// File: rtl/cpu_pkg.sv
// Shared pipeline-register definitions: default bus widths, the NOP encoding and the bubble record.
// Latency: none (types and constants only).
// Backpressure: none; the stall/flush semantics live in the pipeline registers that use this package.
package cpu_pkg;

    localparam int PC_W_DEF    = 64;
    localparam int INSTR_W_DEF = 32;

    // Encoding the decode stage treats as "do nothing"; used as the bubble instruction.
    localparam logic [31:0] NOP = 32'hD503201F;

    // Contents of one pipeline slot; later pipeline registers carry the same triple.
    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
        logic                   valid;
    } bubble_t;

    localparam bubble_t BUBBLE = '{pc: '0, instr: NOP, valid: 1'b0};

endpackage

// File: rtl/if_id_stage_if.sv
// Bundle between fetch/hazard logic (master) and the IF/ID register (slave), plus debug counters.
// Latency: none (wires only).
// Backpressure: stall from the master freezes the slave's outputs; flush overrides stall.
interface if_id_stage_if #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic [PC_W-1:0]    pc_in;
    logic [INSTR_W-1:0] instr_in;
    logic               valid_in;
    logic               stall;
    logic               flush;
    logic [PC_W-1:0]    pc_out;
    logic [INSTR_W-1:0] instr_out;
    logic               valid_out;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output pc_in, instr_in, valid_in, stall, flush,
        input  pc_out, instr_out, valid_out, stall_cnt, flush_cnt
    );

    modport slave (
        input  pc_in, instr_in, valid_in, stall, flush,
        output pc_out, instr_out, valid_out, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/stage_reg.sv
// Bank of enable flip-flops with a clear-to-constant input select, built from gate primitives.
// Latency: 1 cycle from d to q when enabled.
// Backpressure: hold=1 keeps q; clr=1 loads CLR_VAL regardless of hold.
module stage_reg #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    wire             nHold;
    wire             nClr;
    wire             loadEn;
    wire [WIDTH-1:0] keepBit;
    wire [WIDTH-1:0] clrBit;
    wire [WIDTH-1:0] dSel;

    // Clear must win over hold, so the enable is clr OR NOT hold.
    not gNotHold (nHold, hold);
    not gNotClr  (nClr, clr);
    or  gEn      (loadEn, clr, nHold);

    // Per-bit 2:1 select: the clear constant when clr, otherwise the incoming bus.
    for (genvar i = 0; i < WIDTH; i++) begin : g_sel
        and gKeep (keepBit[i], d[i], nClr);
        and gClr  (clrBit[i], CLR_VAL[i], clr);
        or  gOut  (dSel[i], keepBit[i], clrBit[i]);
    end

    // Capture the selected value when enabled; reset forces the clear constant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= CLR_VAL;
        end else if (loadEn) begin
            q <= dSel;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: holds fetched PC/instruction/valid for decode, plus stall/flush event counters.
// Latency: 1 cycle from fetch inputs to decode outputs on a load edge.
// Backpressure: stall freezes the slot; flush inserts a bubble and overrides stall.
module if_id_stage
    import cpu_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          reset,
    if_id_stage_if.slave  bus
);

    stage_reg #(.WIDTH(PC_W), .CLR_VAL('0)) uPcReg (
        .clk   (clk),
        .reset (reset),
        .hold  (bus.stall),
        .clr   (bus.flush),
        .d     (bus.pc_in),
        .q     (bus.pc_out)
    );

    stage_reg #(.WIDTH(INSTR_W), .CLR_VAL(INSTR_W'(NOP))) uInstrReg (
        .clk   (clk),
        .reset (reset),
        .hold  (bus.stall),
        .clr   (bus.flush),
        .d     (bus.instr_in),
        .q     (bus.instr_out)
    );

    stage_reg #(.WIDTH(1), .CLR_VAL(1'b0)) uValidReg (
        .clk   (clk),
        .reset (reset),
        .hold  (bus.stall),
        .clr   (bus.flush),
        .d     (bus.valid_in),
        .q     (bus.valid_out)
    );

    // Counted events: index 0 = stall actually held the stage (flush absent), index 1 = bubble inserted.
    wire       nFlush;
    wire [1:0] evt;

    not gNotFlush (nFlush, bus.flush);
    and gStallEvt (evt[0], bus.stall, nFlush);
    buf gFlushEvt (evt[1], bus.flush);

    for (genvar k = 0; k < 2; k++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        wire  [CNT_W:0]   carry;
        wire  [CNT_W-1:0] sum;
        wire              notSat;
        wire              cntEn;

        // Ripple incrementer; the final carry is high only when cnt is all ones, i.e. saturated.
        assign carry[0] = 1'b1;
        for (genvar i = 0; i < CNT_W; i++) begin : g_bit
            xor gSum   (sum[i], cnt[i], carry[i]);
            and gCarry (carry[i+1], cnt[i], carry[i]);
        end

        not gNotSat (notSat, carry[CNT_W]);
        and gCntEn  (cntEn, evt[k], notSat);

        // Count the event unless already at the maximum; only reset clears it.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
            end else if (cntEn) begin
                cnt <= sum;
            end
        end
    end

    assign bus.stall_cnt = g_cnt[0].cnt;
    assign bus.flush_cnt = g_cnt[1].cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios then randomized traffic against a slot-level model.
// Latency: outputs compared 100 time units after each rising edge.
// Backpressure: random stall/flush, including mid-cycle pulses that must be ignored.
module tb_if_id_stage;
    import cpu_pkg::*;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    if_id_stage_if #(.PC_W(64), .INSTR_W(32), .CNT_W(CNT_W)) bus ();

    if_id_stage #(.PC_W(64), .INSTR_W(32), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #250 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: the slot contents and the two event tallies.
    bubble_t mSlot;
    int      mStall;
    int      mFlush;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mSlot  = BUBBLE;
        mStall = 0;
        mFlush = 0;
    endtask

    task automatic modelEdge(input logic s, input logic f, input logic v,
                             input logic [63:0] p, input logic [31:0] ins);
        if (f) begin
            mSlot  = BUBBLE;
            mFlush = (mFlush < CMAX) ? mFlush + 1 : CMAX;
        end else if (s) begin
            mStall = (mStall < CMAX) ? mStall + 1 : CMAX;
        end else begin
            mSlot.pc    = p;
            mSlot.instr = ins;
            mSlot.valid = v;
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".pc"},    bus.pc_out,           mSlot.pc);
        check({tag, ".instr"}, 64'(bus.instr_out),   64'(mSlot.instr));
        check({tag, ".valid"}, 64'(bus.valid_out),   64'(mSlot.valid));
        check({tag, ".scnt"},  64'(bus.stall_cnt),   64'(mStall));
        check({tag, ".fcnt"},  64'(bus.flush_cnt),   64'(mFlush));
    endtask

    task automatic drive(input logic s, input logic f, input logic v,
                         input logic [63:0] p, input logic [31:0] ins);
        bus.stall    = s;
        bus.flush    = f;
        bus.valid_in = v;
        bus.pc_in    = p;
        bus.instr_in = ins;
    endtask

    task automatic tick();
        @(posedge clk);
        #100;
    endtask

    // One full edge: apply inputs, clock, advance the model, compare everything.
    task automatic cycle(input string tag, input logic s, input logic f, input logic v,
                         input logic [63:0] p, input logic [31:0] ins);
        drive(s, f, v, p, ins);
        tick();
        modelEdge(s, f, v, p, ins);
        checkAll(tag);
    endtask

    initial begin
        logic        s, f, v;
        logic [63:0] p;
        logic [31:0] ins;

        // Reset held across edges with live-looking inputs.
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 64'h40, 32'h11111111);
        modelReset();
        tick();
        tick();
        checkAll("rst_hold");

        reset = 1'b1;
        cycle("load", 1'b0, 1'b0, 1'b1, 64'h100, 32'h8B020020);
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1'b1, 1'b0, 1'b1, 64'h104, 32'h8B020024);
        end
        cycle("flush_pri", 1'b1, 1'b1, 1'b1, 64'h108, 32'h8B020028);
        cycle("bubble_cap", 1'b0, 1'b0, 1'b0, 64'h200, 32'h12345678);
        cycle("stall_bubble", 1'b1, 1'b0, 1'b1, 64'h204, 32'h9ABCDEF0);
        cycle("load2", 1'b0, 1'b0, 1'b1, 64'h300, 32'hCAFEF00D);

        // Asynchronous reset well before the next edge must clear immediately.
        reset = 1'b0;
        #10;
        modelReset();
        checkAll("rst_async");
        #40;
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            cycle("sat_stall", 1'b1, 1'b0, 1'b1, 64'h400, 32'h0);
        end
        for (int i = 0; i < 18; i++) begin
            cycle("sat_flush", 1'b0, 1'b1, 1'b1, 64'h500, 32'h1);
        end

        reset = 1'b0;
        #10;
        modelReset();
        checkAll("rst_async2");
        #40;
        reset = 1'b1;

        // Random traffic; a mid-cycle opposite pulse on stall/flush precedes the real value.
        for (int i = 0; i < 300; i++) begin
            s   = ($urandom_range(0, 99) < 35);
            f   = ($urandom_range(0, 99) < 12);
            v   = 1'($urandom);
            p   = {$urandom, $urandom};
            ins = $urandom;
            bus.stall = ~s;
            bus.flush = ~f;
            #100;
            cycle("rand", s, f, v, p, ins);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled simulation.
    initial begin
        #20000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline register for the 5-stage CPU: captures the fetched PC and instruction at each rising clock edge and presents them to the decode stage. Each stored bit is an enable flip-flop whose enable is the inverse of the decode-side stall. Flush overrides stall and inserts a bubble. Two saturating event counters record how many cycles the stage spent stalled and how many bubbles it inserted, for performance debug.

## Interface
- `PC_W`, default 64: width of the program counter.
- `INSTR_W`, default 32: width of the instruction word.
- `CNT_W`, default 16: width of each event counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it (0) clears all state immediately.
- `pc_in`  in  PC_W  PC of the fetched instruction.
- `instr_in`  in  INSTR_W  fetched instruction word.
- `valid_in`  in  1  fetch produced a real instruction this cycle.
- `stall`  in  1  hazard unit demands decode hold its current contents.
- `flush`  in  1  taken branch resolved; discard the instruction in this stage.
- `pc_out`  out  PC_W  registered PC to decode.
- `instr_out`  out  INSTR_W  registered instruction to decode.
- `valid_out`  out  1  `instr_out` is a real instruction, not a bubble.
- `stall_cnt`  out  CNT_W  number of cycles in which a stall held the stage.
- `flush_cnt`  out  CNT_W  number of bubbles inserted by flush.

## Operation
- **Reset (`reset`=0):**
  - `pc_out`=0, `instr_out`=NOP, `valid_out`=0.
  - `stall_cnt`=0, `flush_cnt`=0.
  - Reset takes effect asynchronously, mid-cycle included, and overrides all other inputs.
- **Per-edge priority (reset deasserted):** flush > stall > load.
  - **Flush** (`flush`=1, any `stall`):
    - `pc_out`←0, `instr_out`←NOP, `valid_out`←0.
    - `flush_cnt`←`flush_cnt`+1.
    - `stall_cnt` is unchanged.
  - **Stall** (`flush`=0, `stall`=1):
    - All data registers and `valid_out` keep their values (enable=0).
    - `stall_cnt`←`stall_cnt`+1.
  - **Load** (`flush`=0, `stall`=0):
    - `pc_out`←`pc_in`, `instr_out`←`instr_in`, `valid_out`←`valid_in`.
  - A stall while `valid_out`=0 still holds the bubble and still increments `stall_cnt`.
- **Counters:**
  - Unsigned and saturating at 2^CNT_W−1; they never wrap.
  - Cleared only by reset.
- **Bubble capture:** `valid_in`=0 on a load captures `pc_in` and `instr_in` as presented. Downstream must qualify everything with `valid_out`.
- **Data-input selection:**
  - Built as a 2:1 select (flush → constant bubble, else input bus).
  - Enable = `flush` OR NOT `stall`.
  - Realised with gate primitives, not behavioural `always` logic.

## Timing
- Latency: 1 cycle from `pc_in`/`instr_in`/`valid_in` to the outputs on a load edge.
- Combinational select/enable path: at most 3 gate levels at #50 each, i.e. 150 time units. This must settle well within the 500-unit clock period used by all benches.
- `stall` and `flush` are sampled at the rising edge only. A pulse that does not span the edge has no effect.
- Counter increment and saturation compare complete within the same cycle; the counter output is valid from the next edge.
- Reset release is not synchronised inside this block. `reset` must deassert at least one gate delay before a rising edge.

## Structure
- **Shared package `cpu_pkg`:** holds `NOP` (32'hD503201F), the `PC_W`/`INSTR_W` defaults, and a `bubble_t` struct {pc, instr, valid} reused by the later pipeline registers (ID/EX, EX/MEM, MEM/WB).
- **Sub-module `stage_reg`:** a WIDTH-parameterised bank of enable flip-flops with a clear-to-constant select.
  - Instantiated three times: PC, instruction, valid.
  - Reused unchanged by the other pipeline registers.
- **Counters:** implemented in this module as ripple adders with a saturation detect gated onto the enable.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `pc_in`=64'h40, `valid_in`=1 → `pc_out`=0, `instr_out`=NOP, `valid_out`=0, both counters 0. Then assert `reset`=0 mid-cycle after loading → outputs clear before the next edge.
- **Load:** `pc_in`=64'h100, `instr_in`=32'h8B020020, `valid_in`=1, `stall`=0, `flush`=0 → after one edge, `pc_out`=64'h100, `instr_out`=32'h8B020020, `valid_out`=1.
- **Stall:** after the load above, hold `stall`=1 for 3 edges while `pc_in` changes to 64'h104 → outputs stay at 64'h100 / 32'h8B020020 and `stall_cnt`=3.
- **Flush priority:** `stall`=1 and `flush`=1 on the same edge → bubble (`valid_out`=0, `instr_out`=NOP), `flush_cnt`=1, `stall_cnt` unchanged.
- **Saturation:** with CNT_W=4, hold `stall`=1 for 20 edges → `stall_cnt` sticks at 15.
- **Bubble capture:** `valid_in`=0 with `pc_in`=64'h200 on a load → `valid_out`=0 and `pc_out`=64'h200.
